join_any_dispatcher: RTL
========================

# join_any_dispatcher

Hardware join-any controller: accepts one job command, launches two parallel workers (A and B) in the same cycle, and releases the downstream stage as soon as either worker reports completion, without waiting for the other. It sits between the command source and the downstream "continue" stage. It reports which worker won and the launch-to-first-done latency. It then tracks the straggler so a new command is never accepted while a worker is still running.

## Interface
- TS_W, 16, width of the elapsed-cycle counter and `any_time`

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  command request
- start_ready  out  1  high only in IDLE
- job_a_start  out  1  one-cycle launch pulse to worker A
- job_a_done  in  1  one-cycle completion pulse from worker A
- job_b_start  out  1  one-cycle launch pulse to worker B
- job_b_done  in  1  one-cycle completion pulse from worker B
- any_valid  out  1  first-completion result valid to downstream
- any_ready  in  1  downstream accepts result
- any_winner  out  2  01 = A first, 10 = B first, 11 = same cycle
- any_time  out  TS_W  cycles from launch pulse to first done
- all_done  out  1  one-cycle pulse: both workers finished and result consumed
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LAUNCH, WAIT_ANY, PRESENT, DRAIN.
- IDLE: `start_ready`=1. On `start_valid` && `start_ready`, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - `job_a_start` and `job_b_start` both high.
  - Set pending_a and pending_b to 1; clear elapsed counter to 0.
  - Done inputs are ignored in this cycle.
- WAIT_ANY:
  - Counter increments each cycle; it saturates at 2^TS_W-1 and never wraps.
  - In the first cycle where (job_a_done && pending_a) or (job_b_done && pending_b):
    - Latch `any_winner` from the done inputs present in that cycle.
    - Latch `any_time` = counter+1 (saturating).
    - Clear the matching pending flags.
    - Go to PRESENT.
- PRESENT:
  - `any_valid`=1; `any_winner` and `any_time` are held stable until `any_ready`.
  - A done from the remaining pending worker clears its flag; it does not change the results.
  - On handshake: if no flag is pending (including a clear in the same cycle), go to IDLE and pulse `all_done`. Otherwise go to DRAIN.
- DRAIN: on the done of the remaining pending worker, clear its flag, go to IDLE, and pulse `all_done`.
- Spurious done inputs (worker not pending, or state IDLE/LAUNCH) are ignored and have no effect.
- `any_valid` must not depend combinationally on `any_ready`.

## Timing
- Reset values: state IDLE, `start_ready`=1, `job_*_start`=0, `any_valid`=0, `any_winner`=00, `any_time`=0, `all_done`=0, `busy`=0, pending flags 0, counter 0.
- Launch pulse is registered: it appears the cycle after the start handshake.
- With the launch pulse in cycle L and the first done in cycle L+N (N≥1):
  - `any_time`=N.
  - `any_valid` rises in cycle L+N+1.
- Minimum start-to-`any_valid` latency: 3 cycles (start handshake, launch, done at L+1).
- `all_done` is a registered pulse asserted in the cycle the FSM re-enters IDLE, i.e. the cycle after its trigger. `start_ready` is 1 in that same cycle, so back-to-back commands are allowed.
- Reset mid-operation (any state): all outputs return to reset values immediately. Workers are not notified; done pulses arriving after reset are treated as spurious.

## Test plan
- Reset release, then start; A done 20 cycles after launch, B done 30 cycles after launch, any_ready held 1 -> launch pulses together; any_valid rises at L+21 with winner=01, any_time=20; all_done pulses at L+31, one cycle after B done; busy drops with it.
- B done at L+5, A done at L+12, any_ready held 0 until L+40 -> winner=10, any_time=5, outputs stable through L+40; all_done pulse in the cycle after the handshake; no DRAIN visit.
- A and B done both at L+7 -> winner=11, any_time=7; all_done the cycle after the any_valid handshake.
- start_valid held high continuously; A done 3 cycles and B done 4 cycles after each launch -> start_ready high only in IDLE; second launch immediately follows the first all_done cycle; spurious job_a_done in IDLE is ignored.
- TS_W=4, A done 40 cycles after launch -> any_time=15 (saturated, no wrap).
- Assert rst during WAIT_ANY and again during PRESENT -> all outputs at reset values in the same cycle; a late job_b_done after release causes no state change.

Source files
------------

// File: rtl/join_any_dispatcher.sv
// join_any_dispatcher
//   Takes one job command and launches workers A and B together. The
//   downstream stage is released on the first completion, and the block then
//   waits for the straggler before it accepts another command.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start_valid/ready  command handshake (ready only while IDLE)
//   job_a/b_start      one-cycle launch pulses (the cycle after the handshake)
//   job_a/b_done       one-cycle completion pulses from the workers
//   any_valid/ready    first-completion result handshake
//   any_winner         01 = A first, 10 = B first, 11 = same cycle
//   any_time           cycles from launch to first done (saturating)
//   all_done           pulse on re-entering IDLE once both workers are done
//   busy               high in every state except IDLE
module join_any_dispatcher #(
    parameter int TS_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    output logic            job_a_start,
    input  logic            job_a_done,
    output logic            job_b_start,
    input  logic            job_b_done,
    output logic            any_valid,
    input  logic            any_ready,
    output logic [1:0]      any_winner,
    output logic [TS_W-1:0] any_time,
    output logic            all_done,
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ANY, PRESENT, DRAIN} state_t;

    localparam logic [TS_W-1:0] CNT_MAX = '1;
    localparam logic [TS_W-1:0] CNT_ONE = {{(TS_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic            pend_a_q, pend_a_d;
    logic            pend_b_q, pend_b_d;
    logic [TS_W-1:0] cnt_q, cnt_d;
    logic [1:0]      win_q, win_d;
    logic [TS_W-1:0] time_q, time_d;
    logic            all_done_q, all_done_d;

    logic            hit_a, hit_b;
    logic [TS_W-1:0] cnt_inc;

    // A done only counts for a worker that is still outstanding. The pending
    // flags are zero in IDLE and LAUNCH, so spurious dones there fall out.
    assign hit_a   = job_a_done && pend_a_q;
    assign hit_b   = job_b_done && pend_b_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        pend_a_d   = pend_a_q;
        pend_b_d   = pend_b_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        time_d     = time_q;
        all_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) state_d = LAUNCH;
            end
            LAUNCH: begin
                pend_a_d = 1'b1;
                pend_b_d = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT_ANY;
            end
            WAIT_ANY: begin
                // cnt_q holds (cycles since launch - 1), so the +1 value is
                // the launch-to-done distance.
                cnt_d = cnt_inc;
                if (hit_a || hit_b) begin
                    win_d    = {hit_b, hit_a};
                    time_d   = cnt_inc;
                    pend_a_d = pend_a_q & ~hit_a;
                    pend_b_d = pend_b_q & ~hit_b;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                pend_a_d = pend_a_q & ~hit_a;
                pend_b_d = pend_b_q & ~hit_b;
                if (any_ready) begin
                    // Look at the post-clear flags so that a straggler
                    // finishing in the handshake cycle skips DRAIN.
                    if (!pend_a_d && !pend_b_d) begin
                        state_d    = IDLE;
                        all_done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                pend_a_d = pend_a_q & ~hit_a;
                pend_b_d = pend_b_q & ~hit_b;
                if (!pend_a_d && !pend_b_d) begin
                    state_d    = IDLE;
                    all_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            cnt_q      <= '0;
            win_q      <= 2'b00;
            time_q     <= '0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            time_q     <= time_d;
            all_done_q <= all_done_d;
        end
    end

    // Every output is decoded from registered state only, so none of them
    // has a combinational path from an input.
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign job_a_start = (state_q == LAUNCH);
    assign job_b_start = (state_q == LAUNCH);
    assign any_valid   = (state_q == PRESENT);
    assign any_winner  = win_q;
    assign any_time    = time_q;
    assign all_done    = all_done_q;

endmodule
